// File: rtl/spi_line_sequencer_if.sv
// Signal bundle between the SPI byte receiver, the ping-pong line buffer and
// the DSI transmit side. The sequencer uses the master view; its environment uses the slave view.
interface spi_line_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              spi_cs_n;
  logic              spi_byte_valid;
  logic [7:0]        spi_byte;
  logic              wr_en;
  logic [ADDR_W:0]   wr_addr;
  logic [7:0]        wr_data;
  logic              line_req;
  logic              line_bank;
  logic              line_frame_start;
  logic              line_ack;
  logic              line_done;
  logic [8:0]        line_count;
  logic              frame_end;
  logic              err_short;
  logic              err_long;
  logic              err_cmd;
  logic              err_overrun;

  modport master (
    input  spi_cs_n, spi_byte_valid, spi_byte, line_ack, line_done,
    output wr_en, wr_addr, wr_data, line_req, line_bank, line_frame_start,
           line_count, frame_end, err_short, err_long, err_cmd, err_overrun
  );

  modport slave (
    output spi_cs_n, spi_byte_valid, spi_byte, line_ack, line_done,
    input  wr_en, wr_addr, wr_data, line_req, line_bank, line_frame_start,
           line_count, frame_end, err_short, err_long, err_cmd, err_overrun
  );
endinterface

// File: rtl/spi_line_sequencer.sv
// Parses SPI line transactions into a ping-pong line buffer and offers
// completed banks to the DSI transmitter in commit order.
//
// RX state | meaning
// IDLE     | waiting for chip select to fall
// CMD      | waiting for the command byte
// DATA     | writing payload into bank wr_bank
// DROP     | discarding the rest of a rejected transaction
//
// TX state | meaning
// IDLE     | waiting for bank rd_bank to become full
// REQ      | line_req asserted, waiting for line_ack
// BUSY     | transmitter reading bank rd_bank, waiting for line_done
module spi_line_sequencer #(
  parameter int          LINE_BYTES  = 480,
  parameter int          FRAME_LINES = 240,
  parameter logic [7:0]  CMD_FRAME   = 8'h3F,
  parameter logic [7:0]  CMD_LINE    = 8'h6B,
  parameter int          ADDR_W      = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  spi_line_sequencer_if.master  bus
);

  localparam int              CW  = ADDR_W + 1;
  localparam logic [CW-1:0]   LB  = CW'(LINE_BYTES);
  localparam logic [8:0]      FL9 = 9'(FRAME_LINES);

  typedef enum logic [1:0] {RX_IDLE, RX_CMD, RX_DATA, RX_DROP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_BUSY} tx_state_t;

  rx_state_t     rx_state, rx_next;
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          ovf, ovf_next;
  logic          frame_flag, frame_next;
  logic          cs_prev, cs_fall, cs_rise;
  logic          wr_en_c, commit, release_c;
  logic          err_short_c, err_long_c, err_cmd_c, err_ovr_c;
  logic [1:0]    full, bank_frame;
  logic          wr_bank, rd_bank;
  logic [8:0]    line_count_q, lc_next;
  logic          frame_end_q, line_req_q;
  logic          err_short_q, err_long_q, err_cmd_q, err_ovr_q;

  assign cs_fall = cs_prev & ~bus.spi_cs_n;
  assign cs_rise = ~cs_prev & bus.spi_cs_n;

  always_comb begin
    rx_next     = rx_state;
    cnt_next    = cnt;
    ovf_next    = ovf;
    frame_next  = frame_flag;
    wr_en_c     = 1'b0;
    commit      = 1'b0;
    err_short_c = 1'b0;
    err_long_c  = 1'b0;
    err_cmd_c   = 1'b0;
    err_ovr_c   = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (cs_fall) begin
          rx_next  = RX_CMD;
          cnt_next = '0;
          ovf_next = 1'b0;
        end
      end
      RX_CMD: begin
        if (cs_rise) begin
          rx_next = RX_IDLE;
        end else if (bus.spi_byte_valid) begin
          if (bus.spi_byte == CMD_FRAME || bus.spi_byte == CMD_LINE) begin
            frame_next = (bus.spi_byte == CMD_FRAME);
            if (full[wr_bank]) begin
              err_ovr_c = 1'b1;
              rx_next   = RX_DROP;
            end else begin
              rx_next = RX_DATA;
            end
          end else begin
            err_cmd_c = 1'b1;
            rx_next   = RX_DROP;
          end
        end
      end
      RX_DATA: begin
        if (bus.spi_byte_valid) begin
          if (cnt < LB) begin
            wr_en_c  = 1'b1;
            cnt_next = cnt + CW'(1);
          end else begin
            ovf_next = 1'b1;
          end
        end
        // A byte arriving with the closing edge still counts toward the line
        if (cs_rise) begin
          rx_next = RX_IDLE;
          if (ovf_next)             err_long_c  = 1'b1;
          else if (cnt_next == LB)  commit      = 1'b1;
          else                      err_short_c = 1'b1;
        end
      end
      RX_DROP: begin
        if (cs_rise) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // cs_prev resets low so a transaction already in flight at reset release is ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      cnt         <= '0;
      ovf         <= 1'b0;
      frame_flag  <= 1'b0;
      cs_prev     <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_cmd_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      rx_state    <= rx_next;
      cnt         <= cnt_next;
      ovf         <= ovf_next;
      frame_flag  <= frame_next;
      cs_prev     <= bus.spi_cs_n;
      err_short_q <= err_short_c;
      err_long_q  <= err_long_c;
      err_cmd_q   <= err_cmd_c;
      err_ovr_q   <= err_ovr_c;
    end
  end

  always_comb begin
    tx_next   = tx_state;
    release_c = 1'b0;
    unique case (tx_state)
      TX_IDLE: if (full[rd_bank]) tx_next = TX_REQ;
      TX_REQ:  if (bus.line_ack) tx_next = TX_BUSY;
      TX_BUSY: begin
        if (bus.line_done) begin
          release_c = 1'b1;
          tx_next   = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      line_req_q <= 1'b0;
    end else begin
      tx_state   <= tx_next;
      line_req_q <= (tx_next == TX_REQ);
    end
  end

  // Commit and release touch different banks, so both may land in one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full       <= 2'b00;
      bank_frame <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
    end else begin
      if (commit) begin
        full[wr_bank]       <= 1'b1;
        bank_frame[wr_bank] <= frame_flag;
        wr_bank             <= ~wr_bank;
      end
      if (release_c) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_comb begin
    lc_next = line_count_q;
    if (commit) begin
      if (frame_flag)              lc_next = 9'd1;
      else if (line_count_q < FL9) lc_next = line_count_q + 9'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_count_q <= '0;
      frame_end_q  <= 1'b0;
    end else begin
      line_count_q <= lc_next;
      frame_end_q  <= commit && (lc_next == FL9) && (line_count_q != FL9);
    end
  end

  assign bus.wr_en            = wr_en_c;
  assign bus.wr_addr          = wr_en_c ? {wr_bank, cnt[ADDR_W-1:0]} : '0;
  assign bus.wr_data          = wr_en_c ? bus.spi_byte : 8'h00;
  assign bus.line_req         = line_req_q;
  assign bus.line_bank        = rd_bank;
  assign bus.line_frame_start = line_req_q & bank_frame[rd_bank];
  assign bus.line_count       = line_count_q;
  assign bus.frame_end        = frame_end_q;
  assign bus.err_short        = err_short_q;
  assign bus.err_long         = err_long_q;
  assign bus.err_cmd          = err_cmd_q;
  assign bus.err_overrun      = err_ovr_q;

endmodule

// File: tb/tb_spi_line_sequencer.sv
// Scoreboard bench for spi_line_sequencer: writes, line requests and error
// pulses are queued as stimulus is driven and matched as the DUT emits them.
module tb_spi_line_sequencer;
  localparam int AW = 9;
  localparam int LB = 480;
  // Short frame keeps the full-frame sequence well inside the cycle budget
  localparam int FL = 16;
  localparam logic [7:0] C_FRAME = 8'h3F;
  localparam logic [7:0] C_LINE  = 8'h6B;

  localparam int O_OK = 0, O_SHORT = 1, O_LONG = 2, O_CMD = 3, O_OVR = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spi_line_sequencer_if #(.ADDR_W(AW)) bus ();

  spi_line_sequencer #(
    .LINE_BYTES(LB), .FRAME_LINES(FL), .CMD_FRAME(C_FRAME), .CMD_LINE(C_LINE), .ADDR_W(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_val(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  logic [17:0] wq[$];
  logic [1:0]  rq[$];
  int          eq[$];
  int          req_cnt = 0;
  int          fe_cnt  = 0;
  bit          req_prev = 1'b0;
  bit          tx_auto = 1'b0;
  bit          tx_busy = 1'b0;
  bit          exp_bank = 1'b0;
  int          exp_lc = 0;

  always @(negedge clock) begin
    if (!reset) begin
      int code, nerr;
      if (bus.wr_en) begin
        if (wq.size() == 0) chk_val("wr_unexpected", {bus.wr_addr, bus.wr_data}, -1);
        else chk_val("wr", {bus.wr_addr, bus.wr_data}, wq.pop_front());
      end
      nerr = int'(bus.err_short) + int'(bus.err_long) + int'(bus.err_cmd) + int'(bus.err_overrun);
      code = bus.err_short ? O_SHORT : bus.err_long ? O_LONG : bus.err_cmd ? O_CMD :
             bus.err_overrun ? O_OVR : 0;
      if (nerr != 0) begin
        chk_val("err_onehot", nerr, 1);
        if (eq.size() == 0) chk_val("err_unexpected", code, 0);
        else chk_val("err_code", code, eq.pop_front());
      end
      if (bus.line_req && !req_prev) begin
        req_cnt++;
        if (rq.size() == 0) chk_val("req_unexpected", {bus.line_bank, bus.line_frame_start}, -1);
        else chk_val("req", {bus.line_bank, bus.line_frame_start}, rq.pop_front());
      end
      if (bus.frame_end) begin
        fe_cnt++;
        chk_val("frame_end_count", bus.line_count, FL);
      end
    end
    req_prev = bus.line_req;
  end

  initial begin
    bus.line_ack  = 1'b0;
    bus.line_done = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (tx_auto && bus.line_req && !reset) begin
        tx_busy = 1'b1;
        bus.line_ack = 1'b1;
        @(posedge clock); #1 bus.line_ack = 1'b0;
        repeat (49) @(posedge clock);
        #1 bus.line_done = 1'b1;
        @(posedge clock); #1 bus.line_done = 1'b0;
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.spi_byte_valid = 1'b1;
    bus.spi_byte = b;
    tick(1);
    bus.spi_byte_valid = 1'b0;
  endtask

  task automatic send_line(input logic [7:0] cmd, input int nbytes, input int outcome,
                           input int seed);
    logic [7:0] d;
    bus.spi_cs_n = 1'b0;
    tick(1);
    if (outcome == O_CMD || outcome == O_OVR) eq.push_back(outcome);
    send_byte(cmd);
    for (int i = 0; i < nbytes; i++) begin
      d = 8'(i + seed);
      if (outcome <= O_LONG && i < LB) wq.push_back({1'(exp_bank), 9'(i), d});
      send_byte(d);
    end
    bus.spi_cs_n = 1'b1;
    if (outcome == O_OK) begin
      rq.push_back({1'(exp_bank), 1'(cmd == C_FRAME)});
      exp_bank = ~exp_bank;
      exp_lc = (cmd == C_FRAME) ? 1 : ((exp_lc < FL) ? exp_lc + 1 : exp_lc);
    end else if (outcome == O_SHORT || outcome == O_LONG) begin
      eq.push_back(outcome);
    end
    tick(3);
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while ((wq.size() != 0 || rq.size() != 0 || tx_busy || bus.line_req) && c < maxc) begin
      tick(1);
      c++;
    end
    if (c >= maxc) chk_val("wait_idle_timeout", c, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_val({tag, "_line_req"}, bus.line_req, 0);
    chk_val({tag, "_line_count"}, bus.line_count, 0);
    chk_val({tag, "_wr_en"}, bus.wr_en, 0);
    chk_val({tag, "_misc"}, {bus.line_bank, bus.line_frame_start, bus.frame_end, bus.err_short,
                             bus.err_long, bus.err_cmd, bus.err_overrun, bus.wr_addr}, 0);
  endtask

  initial begin
    int req_before;
    bus.spi_cs_n = 1'b1;
    bus.spi_byte_valid = 1'b0;
    bus.spi_byte = 8'h00;
    reset = 1'b1;
    tick(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(2);
    check_reset_outputs("post_rst");

    // First line of a frame, transmitter not yet answering
    send_line(C_FRAME, LB, O_OK, 0);
    chk_val("t1_line_req", bus.line_req, 1);
    chk_val("t1_line_bank", bus.line_bank, 0);
    chk_val("t1_frame_start", bus.line_frame_start, 1);
    chk_val("t1_line_count", bus.line_count, 1);
    chk_val("t1_writes_left", wq.size(), 0);

    // Rest of the frame with an acking transmitter
    tx_auto = 1'b1;
    for (int k = 1; k < FL; k++) begin
      send_line(C_LINE, LB, O_OK, k * 7);
      chk_val("t2_line_count", bus.line_count, exp_lc);
    end
    wait_idle(500);
    chk_val("t2_req_count", req_cnt, FL);
    chk_val("t2_frame_end_pulses", fe_cnt, 1);
    chk_val("t2_line_count_final", bus.line_count, FL);

    send_line(C_LINE, LB, O_OK, 99);
    wait_idle(500);
    chk_val("sat_line_count", bus.line_count, FL);
    chk_val("sat_frame_end_pulses", fe_cnt, 1);

    // Short line: error, no commit, next line reuses the bank
    req_before = req_cnt;
    send_line(C_LINE, 30, O_SHORT, 5);
    chk_val("t3_line_req", bus.line_req, 0);
    chk_val("t3_req_count", req_cnt, req_before);
    chk_val("t3_line_count", bus.line_count, FL);
    send_line(C_LINE, LB, O_OK, 11);
    wait_idle(500);

    // Long line: only LB bytes written, no commit
    req_before = req_cnt;
    send_line(C_LINE, LB + 5, O_LONG, 3);
    chk_val("t4_writes_left", wq.size(), 0);
    chk_val("t4_req_count", req_cnt, req_before);
    wait_idle(500);

    // Both banks full, transmitter silent: third transaction overruns
    tx_auto = 1'b0;
    send_line(C_LINE, LB, O_OK, 21);
    send_line(C_LINE, LB, O_OK, 22);
    send_line(C_LINE, 20, O_OVR, 0);
    chk_val("t5_line_req", bus.line_req, 1);
    chk_val("t5_line_bank", bus.line_bank, 0);
    chk_val("t5_writes_left", wq.size(), 0);

    // Reset clears both banks; the bank-1 request never appears
    bus.spi_cs_n = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    rq.delete();
    exp_bank = 1'b0;
    exp_lc = 0;
    tick(2);
    check_reset_outputs("t6_rst");

    send_line(8'h55, 10, O_CMD, 0);
    chk_val("t6_cmd_writes_left", wq.size(), 0);
    chk_val("t6_cmd_line_req", bus.line_req, 0);

    // Reset in the middle of the payload
    bus.spi_cs_n = 1'b0;
    tick(1);
    send_byte(C_LINE);
    for (int i = 0; i < 200; i++) begin
      wq.push_back({1'b0, 9'(i), 8'(i + 40)});
      send_byte(8'(i + 40));
    end
    reset = 1'b1;
    bus.spi_cs_n = 1'b1;
    tick(1);
    check_reset_outputs("t6_midrst");
    reset = 1'b0;
    tick(2);
    chk_val("t6_partial_writes_left", wq.size(), 0);
    check_reset_outputs("t6_after_midrst");

    send_line(C_FRAME, LB, O_OK, 77);
    chk_val("t6_line_req", bus.line_req, 1);
    chk_val("t6_line_bank", bus.line_bank, 0);
    chk_val("t6_line_count", bus.line_count, 1);

    tick(5);
    chk_val("end_writes_left", wq.size(), 0);
    chk_val("end_errors_left", eq.size(), 0);
    chk_val("end_reqs_left", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
